// File: rtl/lsu.sv
// Load/store unit: EX address/lane steering, DF load alignment, WB register.
// Optional LSU_MISALIGN_CHECK_EN blocks, flags and counts misaligned accesses.
module lsu #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_load,
  input  logic             ex_store,
  input  logic             ex_byte_ls,
  input  logic             ex_half_ls,
  input  logic             ex_uns_ls,
  input  logic [31:0]      ex_addr,
  input  logic [31:0]      ex_store_data,
  output logic [31:0]      dmem_addr,
  output logic             dmem_ren,
  output logic [3:0]       dmem_wen,
  output logic [31:0]      dmem_wdata,
  input  logic [31:0]      dmem_rdata,
  output logic [31:0]      df_ld_data,
  output logic [31:0]      wb_ld_data,
  output logic             misalign,
  output logic [CNT_W-1:0] misalign_cnt
);

  typedef struct packed {
    logic       ld;
    logic       is_b;
    logic       is_h;
    logic       uns;
    logic [1:0] off;
    logic       blk;
  } df_t;

  logic       sz_b;
  logic       sz_h;
  logic       sz_w;
  logic       mis;
  logic       blocked;
  logic [1:0] eff_off;
  df_t        df_q;

  assign sz_b = ex_byte_ls;
  assign sz_h = !ex_byte_ls && ex_half_ls;
  assign sz_w = !ex_byte_ls && !ex_half_ls;
  assign mis  = (sz_h && ex_addr[0]) ||
                (sz_w && (ex_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_CHECK_EN
  assign blocked = (ex_load || ex_store) && mis;
`else
  assign blocked = 1'b0;
`endif

  assign dmem_addr = {ex_addr[31:2], 2'b00};
  assign dmem_ren  = ex_load && !ex_store && !blocked;

  // Offset with sub-alignment bits cleared.
  always_comb begin
    eff_off = 2'b00;
    unique case (1'b1)
      sz_b:    eff_off = ex_addr[1:0];
      sz_h:    eff_off = {ex_addr[1], 1'b0};
      default: eff_off = 2'b00;
    endcase
  end

  // Store byte enables and lane replication.
  always_comb begin
    dmem_wen   = 4'b0000;
    dmem_wdata = ex_store_data;
    unique case (1'b1)
      sz_b: begin
        dmem_wdata = {4{ex_store_data[7:0]}};
        dmem_wen   = 4'b0001 << ex_addr[1:0];
      end
      sz_h: begin
        dmem_wdata = {2{ex_store_data[15:0]}};
        dmem_wen   = ex_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        dmem_wdata = ex_store_data;
        dmem_wen   = 4'b1111;
      end
    endcase
    if (!ex_store || blocked)
      dmem_wen = 4'b0000;
  end

  // EX -> DF pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      df_q <= '0;
    end else begin
      df_q.ld   <= ex_load && !ex_store;
      df_q.is_b <= sz_b;
      df_q.is_h <= sz_h;
      df_q.uns  <= ex_uns_ls;
      df_q.off  <= eff_off;
      df_q.blk  <= blocked;
    end
  end

  // Select and extend the loaded lane.
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'h00;
    unique case (df_q.off)
      2'd0: b = dmem_rdata[7:0];
      2'd1: b = dmem_rdata[15:8];
      2'd2: b = dmem_rdata[23:16];
      default: b = dmem_rdata[31:24];
    endcase
    h = df_q.off[1] ? dmem_rdata[31:16]
                    : dmem_rdata[15:0];
    df_ld_data = dmem_rdata;
    unique case (1'b1)
      df_q.is_b:
        df_ld_data = {{24{b[7] & ~df_q.uns}}, b};
      df_q.is_h:
        df_ld_data = {{16{h[15] & ~df_q.uns}}, h};
      default:
        df_ld_data = dmem_rdata;
    endcase
    if (!df_q.ld || df_q.blk)
      df_ld_data = 32'h0;
  end

  // DF -> WB load result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wb_ld_data <= 32'h0;
    else
      wb_ld_data <= df_ld_data;
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = df_q.blk;

  // Saturating count of blocked accesses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      misalign_cnt <= '0;
    else if (blocked && (misalign_cnt != '1))
      misalign_cnt <= misalign_cnt + 1'b1;
  end
`else
  assign misalign     = 1'b0;
  assign misalign_cnt = '0;
`endif

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: stores checked inline, loads checked at WB.
// Load results are queued at issue and popped two clocks later.
module tb_lsu;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ex_load = 1'b0;
  logic             ex_store = 1'b0;
  logic             ex_byte_ls = 1'b0;
  logic             ex_half_ls = 1'b0;
  logic             ex_uns_ls = 1'b0;
  logic [31:0]      ex_addr = 32'h0;
  logic [31:0]      ex_store_data = 32'h0;
  logic [31:0]      dmem_addr;
  logic             dmem_ren;
  logic [3:0]       dmem_wen;
  logic [31:0]      dmem_wdata;
  logic [31:0]      dmem_rdata = 32'hBAD0BAD0;
  logic [31:0]      df_ld_data;
  logic [31:0]      wb_ld_data;
  logic             misalign;
  logic [CNT_W-1:0] misalign_cnt;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb_q[$];
  logic s1, s2;

  lsu #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_load(ex_load), .ex_store(ex_store),
    .ex_byte_ls(ex_byte_ls), .ex_half_ls(ex_half_ls),
    .ex_uns_ls(ex_uns_ls), .ex_addr(ex_addr),
    .ex_store_data(ex_store_data),
    .dmem_addr(dmem_addr), .dmem_ren(dmem_ren),
    .dmem_wen(dmem_wen), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .df_ld_data(df_ld_data),
    .wb_ld_data(wb_ld_data), .misalign(misalign),
    .misalign_cnt(misalign_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h80FF_FFFF;
      32'h0000_2000: return 32'h7FFF_1234;
      32'h0000_0040: return 32'hDEAD_BEEF;
      default:       return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endcase
  endfunction

  function automatic logic mis_model(input logic b, h,
                                     input logic [31:0] a);
    if (b) return 1'b0;
    if (h) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] ld_model(input logic b, h, u,
                                           input logic [31:0] a);
    logic [31:0] rd;
    logic [31:0] v;
    rd = mem_rd({a[31:2], 2'b00});
`ifdef LSU_MISALIGN_CHECK_EN
    if (mis_model(b, h, a)) return 32'h0;
`endif
    if (b) begin
      v = rd >> (8 * a[1:0]);
      return u ? {24'h0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    end
    if (h) begin
      v = a[1] ? rd >> 16 : rd;
      return u ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    end
    return rd;
  endfunction

  always @(posedge clk) begin
    if (dmem_ren) dmem_rdata <= mem_rd(dmem_addr);
    else          dmem_rdata <= 32'hBAD0BAD0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= ex_load && !ex_store;
      s2 <= s1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [31:0] exp;
      exp = 32'h0;
      if (s2) begin
        if (sb_q.size() == 0) begin
          fails++;
          $display("FAIL sb_underflow wb=%h", wb_ld_data);
        end else begin
          exp = sb_q.pop_front();
        end
      end
      tests++;
      if (wb_ld_data !== exp) begin
        fails++;
        $display("FAIL wb_ld_data got=%h exp=%h", wb_ld_data, exp);
      end
    end
  end

  task automatic drive(input logic ld, st, b, h, u,
                       input logic [31:0] a, sd);
    @(negedge clk);
    ex_load = ld; ex_store = st;
    ex_byte_ls = b; ex_half_ls = h; ex_uns_ls = u;
    ex_addr = a; ex_store_data = sd;
    if (ld && !st) sb_q.push_back(ld_model(b, h, u, a));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    #2;
    tests++;
    if (wb_ld_data !== 32'h0 || misalign !== 1'b0 ||
        misalign_cnt !== '0) begin
      fails++;
      $display("FAIL reset wb=%h mis=%b cnt=%0d",
               wb_ld_data, misalign, misalign_cnt);
    end
    tests++;
    if (dmem_ren !== 1'b0 || dmem_wen !== 4'b0000) begin
      fails++;
      $display("FAIL reset_strobes ren=%b wen=%b", dmem_ren, dmem_wen);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_store;
    logic [3:0]  w[3] = '{4'b0100, 4'b1100, 4'b1111};
    logic [31:0] d[3] = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'h1234BEEF};
    logic [31:0] ad[3] = '{32'h1002, 32'h1002, 32'h1004};
    logic [31:0] sd[3] = '{32'h000000A5, 32'h1234BEEF, 32'h1234BEEF};
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, i == 0, i == 1, 0, ad[i], sd[i]);
      #1;
      tests++;
      if (dmem_addr !== {ad[i][31:2], 2'b00} || dmem_wen !== w[i] ||
          dmem_wdata !== d[i] || dmem_ren !== 1'b0) begin
        fails++;
        $display("FAIL store%0d addr=%h wen=%b wd=%h ren=%b exp wen=%b wd=%h",
                 i, dmem_addr, dmem_wen, dmem_wdata, dmem_ren, w[i], d[i]);
      end
    end
    drive(0, 1, 1, 0, 0, 32'h1001, 32'h0000_003C);
    #1;
    tests++;
    if (dmem_wen !== 4'b0010 || dmem_wdata !== 32'h3C3C3C3C) begin
      fails++;
      $display("FAIL sb_off1 wen=%b wd=%h", dmem_wen, dmem_wdata);
    end
    idle(1);
  endtask

  task automatic test_loads;
    drive(1, 0, 1, 0, 0, 32'h103, 32'h0);
    #1;
    tests++;
    if (dmem_ren !== 1'b1 || dmem_addr !== 32'h100 ||
        dmem_wen !== 4'b0000) begin
      fails++;
      $display("FAIL lb_strobe ren=%b addr=%h wen=%b",
               dmem_ren, dmem_addr, dmem_wen);
    end
    drive(1, 0, 1, 0, 1, 32'h103, 32'h0);
    drive(1, 0, 0, 1, 0, 32'h2002, 32'h0);
    drive(1, 0, 0, 1, 1, 32'h2000, 32'h0);
    drive(1, 0, 0, 0, 0, 32'h2000, 32'h0);
    drive(1, 0, 0, 1, 0, 32'h2001, 32'h0);
    drive(1, 0, 0, 0, 0, 32'h0040, 32'h0);
    drive(1, 0, 0, 0, 0, 32'h2003, 32'h0);
    idle(3);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = $urandom_range(0, 16'hFFFF);
      sz = 2'($urandom_range(0, 2));
      if (sz == 1) a[0] = 1'b0;
      if (sz == 2) a[1:0] = 2'b00;
      drive(1, 0, sz == 0, sz == 1, 1'($urandom_range(0, 1)), a, 32'h0);
    end
    idle(3);
  endtask

  task automatic test_concurrent;
    drive(1, 1, 0, 0, 0, 32'h10, 32'h0BAD_F00D);
    #1;
    tests++;
    if (dmem_ren !== 1'b0 || dmem_wen !== 4'b1111 ||
        dmem_wdata !== 32'h0BADF00D) begin
      fails++;
      $display("FAIL ld_st ren=%b wen=%b wd=%h",
               dmem_ren, dmem_wen, dmem_wdata);
    end
    idle(3);
  endtask

  task automatic test_misalign;
`ifdef LSU_MISALIGN_CHECK_EN
    drive(0, 1, 0, 0, 0, 32'h3001, 32'h1111_2222);
    #1;
    tests++;
    if (dmem_wen !== 4'b0000) begin
      fails++;
      $display("FAIL sw_blk wen=%b exp=0000", dmem_wen);
    end
    idle(1);
    #1;
    tests++;
    if (misalign !== 1'b1 || misalign_cnt !== 8'd1) begin
      fails++;
      $display("FAIL mis_pulse mis=%b cnt=%0d exp 1/1",
               misalign, misalign_cnt);
    end
    drive(1, 0, 0, 1, 0, 32'h2001, 32'h0);
    #1;
    tests++;
    if (dmem_ren !== 1'b0) begin
      fails++;
      $display("FAIL lh_blk ren=%b exp=0", dmem_ren);
    end
    for (int i = 0; i < 298; i++)
      drive(0, 1, 0, 0, 0, 32'h3001, 32'h0);
    idle(2);
    #1;
    tests++;
    if (misalign_cnt !== 8'd255 || misalign !== 1'b0) begin
      fails++;
      $display("FAIL mis_sat cnt=%0d mis=%b exp 255/0",
               misalign_cnt, misalign);
    end
`else
    drive(0, 1, 0, 0, 0, 32'h3001, 32'h1111_2222);
    #1;
    tests++;
    if (dmem_wen !== 4'b1111 || dmem_addr !== 32'h3000) begin
      fails++;
      $display("FAIL sw_noblk wen=%b addr=%h", dmem_wen, dmem_addr);
    end
    idle(1);
    #1;
    tests++;
    if (misalign !== 1'b0 || misalign_cnt !== '0) begin
      fails++;
      $display("FAIL mis_tied mis=%b cnt=%0d", misalign, misalign_cnt);
    end
`endif
    idle(2);
  endtask

  task automatic test_reset_inflight;
    drive(1, 0, 0, 0, 0, 32'h44, 32'h0);
    drive(1, 0, 0, 0, 0, 32'h40, 32'h0);
    idle(1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    tests++;
    if (wb_ld_data !== 32'h0 || df_ld_data !== 32'h0 ||
        misalign_cnt !== '0 || misalign !== 1'b0) begin
      fails++;
      $display("FAIL rst_flight wb=%h df=%h cnt=%0d mis=%b",
               wb_ld_data, df_ld_data, misalign_cnt, misalign);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    drive(1, 0, 0, 0, 0, 32'h40, 32'h0);
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_store;
    test_loads;
    test_back_to_back;
    test_concurrent;
    test_misalign;
    test_reset_inflight;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover size=%0d exp=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
